// File: rtl/fmap_stream_reader.sv
// Feature-map reader: sync-read BRAM in raster order -> valid/ready pixel stream with sof/eol/eof.
// Optional zero border of PAD pixels around the frame when FMAP_PAD_EN is defined.

// fmap_fifo: generic first-word-fall-through FIFO.
// Latency: a pushed entry is visible at the head on the next cycle.
// Backpressure: none internally; caller must not push when full nor pop when empty.
module fmap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
endmodule

// fmap_stream_reader: streams one IMG_W x IMG_H map (padded if FMAP_PAD_EN) from BRAM.
// Latency: start at cycle 0, mem_en at cycle 1, first px_valid at cycle 3; 1 pixel/cycle.
// Backpressure: px_ready low freezes the head; reads stop once 2 pixels are outstanding.
module fmap_stream_reader #(
    parameter int WIDTH  = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int PAD    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [WIDTH-1:0]  px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_sof,
    output logic              px_eol,
    output logic              px_eof
);
`ifdef FMAP_PAD_EN
    localparam int P = PAD;
`else
    // Without padding the border width has no effect.
    localparam int P = PAD * 0;
`endif
    localparam int OW = IMG_W + 2 * P;
    localparam int OH = IMG_H + 2 * P;
    localparam int CW = $clog2(OW);
    localparam int RW = $clog2(OH);
    localparam int FW = WIDTH + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [ADDR_W-1:0] addr;
    logic              issue;
    logic              is_pad;
    logic              last_px;
    logic              pop;
    logic [2:0]        pending;

    logic              fl_vld;
    logic              fl_pad;
    logic              fl_sof;
    logic              fl_eol;
    logic              fl_eof;

    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic [FW-1:0]     fifo_in;
    logic [FW-1:0]     fifo_head;

`ifdef FMAP_PAD_EN
    assign is_pad = (row < RW'(P)) || (row >= RW'(P + IMG_H)) ||
                    (col < CW'(P)) || (col >= CW'(P + IMG_W));
`else
    assign is_pad = 1'b0;
`endif

    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    assign px_valid = !fifo_empty;
    assign pop      = px_valid && px_ready;

    // Count FIFO entries plus the read in flight; a slot freed this cycle can be reused.
    assign pending  = {1'b0, fifo_cnt} + {2'b00, fl_vld};
    assign issue    = (state == READ) && (pending < (3'd2 + {2'b00, pop}));
    assign mem_en   = issue && !is_pad;
    assign mem_addr = addr;

    assign busy = (state == READ) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (issue && last_px) state_nxt = DRAIN;
            DRAIN: if (!fl_vld && (fifo_empty || (fifo_cnt == 2'd1 && pop))) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (state == IDLE && start) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (issue) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (mem_en) addr <= addr + ADDR_W'(1);
        end
    end

    // Tags travel alongside the BRAM read so they meet the data it returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_vld <= 1'b0;
            fl_pad <= 1'b0;
            fl_sof <= 1'b0;
            fl_eol <= 1'b0;
            fl_eof <= 1'b0;
        end else begin
            fl_vld <= issue;
            fl_pad <= is_pad;
            fl_sof <= (row == '0) && (col == '0);
            fl_eol <= (col == COL_LAST);
            fl_eof <= last_px;
        end
    end

    assign fifo_in = {(fl_pad ? {WIDTH{1'b0}} : mem_data), fl_sof, fl_eol, fl_eof};

    fmap_fifo #(.WIDTH(FW), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fl_vld),
        .push_dat (fifo_in),
        .pop      (pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign {px_data, px_sof, px_eol, px_eof} = px_valid ? fifo_head : '0;
endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader with a 4x3 map, mem[i] = i+1.
module tb_fmap_stream_reader;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int AW = 10;
`ifdef FMAP_PAD_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int OW = W + 2 * P;
    localparam int OH = H + 2 * P;
    localparam int N  = OW * OH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          px_ready = 1'b1;
    logic          busy, done, mem_en, px_valid, px_sof, px_eol, px_eof;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] px_data;
    logic [DW-1:0] mem [2**AW];

    int n_checks = 0;
    int n_err    = 0;
    int cyc       = 0;
    int start_cyc = 0;

    fmap_stream_reader #(
        .WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PAD(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .px_data  (px_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_sof   (px_sof),
        .px_eol   (px_eol),
        .px_eof   (px_eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {data, sof, eol, eof} for the k-th pixel of the output frame.
    function automatic logic [31:0] exp_pix(input int k);
        int r, c, d;
        r = k / OW;
        c = k % OW;
        if (r < P || r >= P + H || c < P || c >= P + W) d = 0;
        else d = (r - P) * W + (c - P) + 1;
        return {21'd0, d[7:0], (k == 0), (c == OW - 1), (k == N - 1)};
    endfunction

    // Passive monitor, sampled on the falling edge.
    logic [DW+2:0] cap_q [$];
    int            cap_rel [$];
    int            en_rel [$];
    int rel;
    int nhs = 0, done_cnt = 0, done_rel = 0, busy_at_done = 0, busy_rise = -1;
    int en_nr = 0, out_cnt = 0, max_out = 0, hold_bad = 0, mark_bad = 0;
    logic prev_stall = 1'b0, prev_busy = 1'b0;
    logic [DW+2:0] prev_pix = '0;

    always @(negedge clk) begin
        if (rst) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            rel = cyc - start_cyc;
            if (prev_stall && (!px_valid || {px_data, px_sof, px_eol, px_eof} !== prev_pix)) hold_bad++;
            if (!px_valid && {px_sof, px_eol, px_eof} != 3'b000) mark_bad++;
            if (out_cnt > max_out) max_out = out_cnt;
            if (mem_en) begin
                en_rel.push_back(rel);
                out_cnt++;
                if (!px_ready) en_nr++;
            end
            if (px_valid && px_ready) begin
                cap_q.push_back({px_data, px_sof, px_eol, px_eof});
                cap_rel.push_back(rel);
                nhs++;
                out_cnt--;
            end
            if (done) begin
                done_cnt++;
                done_rel     = rel;
                busy_at_done = busy;
            end
            if (busy && !prev_busy) busy_rise = rel;
            prev_busy  = busy;
            prev_stall = px_valid && !px_ready;
            prev_pix   = {px_data, px_sof, px_eol, px_eof};
        end
    end

    // mode 0: ready high, 1: ready toggles, 2: 10-cycle stall after pixel 5.
    task automatic run_frame(input int mode, input bit poke, input string nm);
        int en0, hs0, dn0, nr0, stall_at, rel_now;
        bit got_done;
        en0 = en_rel.size();
        hs0 = nhs;
        dn0 = done_cnt;
        nr0 = en_nr;
        stall_at = -1;
        got_done = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        px_ready  = 1'b1;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            rel_now = cyc - start_cyc;
            if (poke && (rel_now == 5 || rel_now == 3 + N)) start = 1'b1;
            case (mode)
                1: px_ready = (rel_now % 2 == 0);
                2: begin
                    if (stall_at < 0 && nhs - hs0 == 5) stall_at = rel_now;
                    px_ready = !(stall_at >= 0 && rel_now < stall_at + 10);
                end
                default: px_ready = 1'b1;
            endcase
            got_done = (done_cnt > dn0);
        end
        start    = 1'b0;
        px_ready = 1'b1;
        repeat (poke ? 12 : 2) @(posedge clk);
        #1;
        check_eq({nm, ".done_cnt"}, done_cnt - dn0, 1);
        check_eq({nm, ".npix"}, nhs - hs0, N);
        for (int i = 0; i < N; i++)
            check_eq($sformatf("%s.pix%0d", nm, i),
                     (hs0 + i < cap_q.size()) ? {21'd0, cap_q[hs0 + i]} : 32'hDEAD_BEEF, exp_pix(i));
        check_eq({nm, ".n_reads"}, en_rel.size() - en0, W * H);
        check_eq({nm, ".busy_rise"}, busy_rise, 1);
        check_eq({nm, ".busy_at_done"}, busy_at_done, 0);
        if (nhs - hs0 == N) check_eq({nm, ".done_rel"}, done_rel, cap_rel[nhs - 1] + 1);
        if (mode == 0 && nhs - hs0 == N) begin
            check_eq({nm, ".first_px_cyc"}, cap_rel[hs0], 3);
            check_eq({nm, ".last_px_cyc"}, cap_rel[nhs - 1], 3 + N - 1);
            check_eq({nm, ".first_en_cyc"}, en_rel[en0], 1 + P * OW + P);
        end
        if (mode == 2) check_eq({nm, ".en_in_stall"}, en_nr - nr0, 0);
        if (poke) check_eq({nm, ".busy_after"}, busy, 0);
        check_eq({nm, ".hold_bad"}, hold_bad, 0);
        check_eq({nm, ".mark_bad"}, mark_bad, 0);
        check_eq({nm, ".outstanding_le2"}, (max_out <= 2), 1);
    endtask

    int hs_t5;

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset.outs",
                 {busy, done, mem_en, mem_addr, px_valid, px_data, px_sof, px_eol, px_eof}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_frame(0, 1'b0, "t1");
        run_frame(1, 1'b0, "t2");
        run_frame(2, 1'b0, "t3");
        run_frame(0, 1'b1, "t4a");
        run_frame(0, 1'b0, "t4b");

        hs_t5 = nhs;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        px_ready  = 1'b1;
        for (int k = 0; k < 100 && nhs - hs_t5 < 7; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        start = 1'b0;
        check_eq("t5.pix_before_rst", nhs - hs_t5, 7);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("t5.rst_outs",
                     {busy, done, mem_en, mem_addr, px_valid, px_data, px_sof, px_eol, px_eof}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        run_frame(0, 1'b0, "t5");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
